// File: rtl/shift_reg_burst_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_burst_if
// Description : Control/data bundle between a burst controller and
//               shift_reg_burst.
//               The controller side (master) drives:
//                 load, preset_value, start, shift_count, dir, mode, serial_in
//               The register side (slave) drives:
//                 out, serial_out, busy, done
//                 parity_out  (only when SHIFT_REG_BURST_PARITY_EN is defined)
// Config      : SHIFT_REG_BURST_PARITY_EN adds the parity_out signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_reg_burst_if #(
    parameter int WIDTH = 31,
    parameter int CNT_W = 6
);
    // Controller -> register
    logic             load;
    logic [WIDTH-1:0] preset_value;
    logic             start;
    logic [CNT_W-1:0] shift_count;
    logic             dir;
    logic [1:0]       mode;
    logic             serial_in;

    // Register -> controller
    logic [WIDTH-1:0] out;
    logic             serial_out;
    logic             busy;
    logic             done;
`ifdef SHIFT_REG_BURST_PARITY_EN
    logic             parity_out;

    modport master (
        output load, preset_value, start, shift_count, dir, mode, serial_in,
        input  out, serial_out, busy, done, parity_out
    );

    modport slave (
        input  load, preset_value, start, shift_count, dir, mode, serial_in,
        output out, serial_out, busy, done, parity_out
    );
`else
    modport master (
        output load, preset_value, start, shift_count, dir, mode, serial_in,
        input  out, serial_out, busy, done
    );

    modport slave (
        input  load, preset_value, start, shift_count, dir, mode, serial_in,
        output out, serial_out, busy, done
    );
`endif

endinterface : shift_reg_burst_if
`default_nettype wire

// File: rtl/shift_reg_burst.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_burst
// Description : Parametrised preset/serial shift register with a counted
//               burst engine. A controller loads a word, requests N shifts
//               with a direction and feedback mode, and waits for done.
//               Feedback modes: 00 serial, 01 rotate, 10 LFSR, 11 zero-fill.
// Ports       : qzt_clk   - system clock, rising edge
//               rst       - asynchronous reset, active-high
//               bus       - shift_reg_burst_if.slave
//                           in : load, preset_value, start, shift_count,
//                                dir, mode, serial_in
//                           out: out, serial_out, busy, done
//                                (+ parity_out with SHIFT_REG_BURST_PARITY_EN)
// Config      : `define SHIFT_REG_BURST_PARITY_EN to add a registered
//               XOR-reduction of out on bus.parity_out.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_burst #(
    parameter int               WIDTH = 31,
    parameter int               CNT_W = 6,
    parameter logic [WIDTH-1:0] TAPS  = 31'h48000000
) (
    input  wire               qzt_clk,
    input  wire               rst,
    shift_reg_burst_if.slave  bus
);

    localparam logic [1:0] MODE_SERIAL = 2'b00;
    localparam logic [1:0] MODE_ROTATE = 2'b01;
    localparam logic [1:0] MODE_LFSR   = 2'b10;
    localparam logic [1:0] MODE_ZERO   = 2'b11;

    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [WIDTH-1:0] r_out;
    logic             r_serial_out;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic [1:0]       r_mode;

    state_t           w_state_next;
    logic [WIDTH-1:0] w_out_next;
    logic             w_serial_out_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_dir_next;
    logic [1:0]       w_mode_next;

    // ------------------------------------------------------------------
    // Shift datapath, driven only by the latched direction/mode so that
    // mid-burst changes on the bus cannot disturb an active burst.
    // ------------------------------------------------------------------
    logic             w_bit_out;
    logic             w_in_bit;
    logic [WIDTH-1:0] w_shifted;

    always_comb begin
        w_bit_out = r_dir ? r_out[WIDTH-1] : r_out[0];

        w_in_bit = 1'b0;
        case (r_mode)
            MODE_SERIAL: w_in_bit = bus.serial_in;
            MODE_ROTATE: w_in_bit = w_bit_out;
            // Taken from the pre-shift word; an all-zero word stays zero.
            MODE_LFSR:   w_in_bit = ^(r_out & TAPS);
            MODE_ZERO:   w_in_bit = 1'b0;
            default:     w_in_bit = 1'b0;
        endcase

        if (r_dir) begin
            w_shifted = {r_out[WIDTH-2:0], w_in_bit};
        end else begin
            w_shifted = {w_in_bit, r_out[WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-data logic. load overrides everything (rst aside):
    // it presets the word and drops any burst in progress without a done.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_out_next        = r_out;
        w_serial_out_next = r_serial_out;
        w_cnt_next        = r_cnt;
        w_dir_next        = r_dir;
        w_mode_next       = r_mode;

        if (bus.load) begin
            w_out_next        = bus.preset_value;
            // Uses the live dir input: there is no latched direction yet.
            w_serial_out_next = bus.dir ? bus.preset_value[WIDTH-1]
                                        : bus.preset_value[0];
            w_state_next      = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.shift_count != '0) begin
                            w_cnt_next   = bus.shift_count;
                            w_dir_next   = bus.dir;
                            w_mode_next  = bus.mode;
                            w_state_next = ST_SHIFT;
                        end else begin
                            // Zero-length burst: straight to completion.
                            w_state_next = ST_DONE;
                        end
                    end
                end

                ST_SHIFT: begin
                    w_out_next        = w_shifted;
                    w_serial_out_next = w_bit_out;
                    w_cnt_next        = r_cnt - C_CNT_ONE;
                    if (r_cnt == C_CNT_ONE) begin
                        w_state_next = ST_DONE;
                    end
                end

                ST_DONE: begin
                    w_state_next = ST_IDLE;
                end

                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge qzt_clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_out        <= '0;
            r_serial_out <= 1'b0;
            r_cnt        <= '0;
            r_dir        <= 1'b0;
            r_mode       <= MODE_SERIAL;
        end else begin
            r_state      <= w_state_next;
            r_out        <= w_out_next;
            r_serial_out <= w_serial_out_next;
            r_cnt        <= w_cnt_next;
            r_dir        <= w_dir_next;
            r_mode       <= w_mode_next;
        end
    end

    // busy/done decode straight from the state register, so reset clears
    // them immediately without waiting for a clock edge.
    assign bus.out        = r_out;
    assign bus.serial_out = r_serial_out;
    assign bus.busy       = (r_state == ST_SHIFT);
    assign bus.done       = (r_state == ST_DONE);

`ifdef SHIFT_REG_BURST_PARITY_EN
    // Parity of the word being written, so it tracks out on the same edge.
    logic r_parity;

    always_ff @(posedge qzt_clk or posedge rst) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= ^w_out_next;
        end
    end

    assign bus.parity_out = r_parity;
`endif

endmodule : shift_reg_burst
`default_nettype wire

// File: tb/tb_shift_reg_burst.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_reg_burst
// Description : Scoreboard bench for shift_reg_burst. Each burst pushes its
//               expected final word, serial_out and busy length; a monitor
//               pops and compares on every done pulse. Direct checks cover
//               reset, abort and parity behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_reg_burst;

    localparam int WIDTH = 31;
    localparam int CNT_W = 6;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] out;
        logic             so;
        int               busy;
    } exp_t;

    logic qzt_clk = 1'b0;
    logic rst     = 1'b1;

    always #5 qzt_clk = ~qzt_clk;

    shift_reg_burst_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    shift_reg_burst #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .TAPS  (31'h48000000)
    ) dut (
        .qzt_clk (qzt_clk),
        .rst     (rst),
        .bus     (bus)
    );

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: counts contiguous busy cycles and scores each done pulse.
    // ------------------------------------------------------------------
    int   busy_run = 0;
    exp_t mon_e;

    always @(negedge qzt_clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_out"},  64'(bus.out),        64'(mon_e.out));
                check({mon_e.name, "_so"},   64'(bus.serial_out), 64'(mon_e.so));
                check({mon_e.name, "_busy"}, 64'(busy_run),       64'(mon_e.busy));
            end
            busy_run = 0;
        end else if (bus.busy === 1'b1) begin
            busy_run++;
        end else begin
            busy_run = 0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers; every helper returns 1 time unit after a rising edge.
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge qzt_clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v, input logic d);
        bus.preset_value = v;
        bus.dir          = d;
        bus.load         = 1'b1;
        tick(1);
        bus.load         = 1'b0;
    endtask

    task automatic do_start(input int n, input logic d, input logic [1:0] m);
        bus.shift_count = CNT_W'(n);
        bus.dir         = d;
        bus.mode        = m;
        bus.start       = 1'b1;
        tick(1);
        bus.start       = 1'b0;
    endtask

    task automatic burst(input string name, input int n, input logic d,
                         input logic [1:0] m, input logic [WIDTH-1:0] eout,
                         input logic eso);
        exp_t e;
        e.name = name;
        e.out  = eout;
        e.so   = eso;
        e.busy = n;
        sb.push_back(e);
        do_start(n, d, m);
        tick(n + 3);
    endtask

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        bus.load         = 1'b0;
        bus.preset_value = '0;
        bus.start        = 1'b0;
        bus.shift_count  = '0;
        bus.dir          = 1'b0;
        bus.mode         = 2'b00;
        bus.serial_in    = 1'b0;

        // Reset state
        #3;
        check("rst_out",  64'(bus.out),        64'd0);
        check("rst_so",   64'(bus.serial_out), 64'd0);
        check("rst_busy", 64'(bus.busy),       64'd0);
        check("rst_done", 64'(bus.done),       64'd0);
        tick(1);
        rst = 1'b0;
        tick(1);

        // Reset mid-burst: outputs clear before the next edge, no done later
        do_load(31'h5, 1'b0);
        do_start(10, 1'b0, 2'b00);
        tick(2);
        #2 rst = 1'b1;
        #1;
        check("midrst_out",  64'(bus.out),  64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        #2 rst = 1'b0;
        tick(14);

        // Serial right, single shift
        do_load(31'h00000001, 1'b0);
        bus.serial_in = 1'b1;
        burst("ser_r", 1, 1'b0, 2'b00, 31'h40000000, 1'b1);

        // Serial left, three ones shifted in
        do_load(31'h0, 1'b1);
        burst("ser_l", 3, 1'b1, 2'b00, 31'h00000007, 1'b0);
        bus.serial_in = 1'b0;

        // Rotate left a full turn
        do_load(31'h12345678, 1'b1);
        burst("rot_l", 31, 1'b1, 2'b01, 31'h12345678, 1'b0);

        // LFSR: seed 1 has no taps set, then a seed with both taps set
        do_load(31'h00000001, 1'b0);
        burst("lfsr0", 3, 1'b0, 2'b10, 31'h0, 1'b0);
        do_load(31'h48000000, 1'b0);
        burst("lfsr1", 1, 1'b0, 2'b10, 31'h24000000, 1'b0);

        // Zero-length burst: done only, word untouched
        burst("zero_len", 0, 1'b0, 2'b00, 31'h24000000, 1'b0);

        // A start during busy must not extend or alter the burst
        do_load(31'h000000FF, 1'b0);
        e.name = "ign_start";
        e.out  = 31'h00000007;
        e.so   = 1'b1;
        e.busy = 5;
        sb.push_back(e);
        do_start(5, 1'b0, 2'b11);
        tick(2);
        do_start(10, 1'b1, 2'b01);
        tick(8);

        // Load aborts a running burst without a done pulse
        do_load(31'h0, 1'b0);
        do_start(20, 1'b0, 2'b00);
        tick(3);
        do_load(31'h7FFFFFFF, 1'b0);
        check("abort_out",  64'(bus.out),        64'h7FFFFFFF);
        check("abort_busy", 64'(bus.busy),       64'd0);
        check("abort_so",   64'(bus.serial_out), 64'd1);
        tick(25);
        check("abort_hold", 64'(bus.out),        64'h7FFFFFFF);

`ifdef SHIFT_REG_BURST_PARITY_EN
        do_load(31'h00000007, 1'b0);
        check("par_load", 64'(bus.parity_out), 64'd1);
        burst("par_shift", 1, 1'b0, 2'b11, 31'h00000003, 1'b1);
        check("par_after", 64'(bus.parity_out), 64'd0);
`endif

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_shift_reg_burst
`default_nettype wire

// File: doc/shift_reg_burst.md
Name: shift_reg_burst

Overview:
- Parametrised successor to the fixed 31-bit preset/serial shift register.
- Adds configurable width, shift direction and feedback mode (serial, rotate, LFSR, zero-fill).
- Adds a counted burst engine with busy/done handshake.
- Sits between control logic and serial links or pattern generators. The controller loads a word, requests N shifts, and waits for done.

Parameters:
- WIDTH, 31, register width in bits (>=2).
- CNT_W, 6, width of shift_count; max burst length is 2^CNT_W-1.
- TAPS, 31'h48000000, LFSR tap mask (bit i set = out[i] feeds XOR). Default gives x^31+x^28+1. Width is WIDTH.

Ports:
- qzt_clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- load  in  1  synchronous preset strobe.
- preset_value  in  WIDTH  word loaded on load.
- start  in  1  burst request pulse; accepted only when idle.
- shift_count  in  CNT_W  number of shifts in the burst; sampled on accepted start.
- dir  in  1  0 = right (toward bit 0), 1 = left; sampled on accepted start.
- mode  in  2  00 serial, 01 rotate, 10 LFSR, 11 zero-fill; sampled on accepted start.
- serial_in  in  1  incoming bit for serial mode; read every shift cycle.
- out  out  WIDTH  register contents.
- serial_out  out  1  registered bit shifted out on the last shift.
- busy  out  1  high while a burst is active.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (asynchronous, any time, including mid-burst):
  - out=0, serial_out=0, busy=0, done=0.
  - Internal counter=0; latched dir=0, latched mode=00.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 with shift_count!=0: latch count/dir/mode, go to SHIFT, busy=1 from the next cycle.
  - start=1 with shift_count=0: go to DONE; no shift; out unchanged.
- SHIFT: one shift per cycle, counter decrements.
  - The cycle that performs the final shift (counter==1) transitions to DONE.
  - Exactly N shifts occur. busy is high for exactly N cycles.
- DONE: done=1 for one cycle, busy=0, return to IDLE. A start in the DONE cycle is ignored.
- Right shift:
  - serial_out <= out[0].
  - out <= {in_bit, out[WIDTH-1:1]}.
- Left shift:
  - serial_out <= out[WIDTH-1].
  - out <= {out[WIDTH-2:0], in_bit}.
- in_bit by mode:
  - serial: serial_in.
  - rotate: the bit being shifted out.
  - LFSR: XOR-reduce(out & TAPS), computed from pre-shift out.
  - zero-fill: 0.
- serial_out changes only on shift or load cycles; otherwise it holds.
- load has priority over everything except rst:
  - out <= preset_value; serial_out <= preset_value[0] when dir input=0, preset_value[WIDTH-1] when dir input=1.
  - If busy, the burst aborts: go to IDLE, busy=0, no done pulse.
- Simultaneous load and start: load wins, start is dropped.
- start while busy or in DONE: ignored; latched parameters do not change.
- Mid-burst changes to dir/mode/shift_count have no effect on the active burst.
- LFSR with out=0 stays 0 (lock-up is legal; the controller must load a nonzero seed).
- Latency: the first shift appears on out one cycle after the start cycle. done rises the cycle after the last shift.

Optional Feature:
- Macro: SHIFT_REG_BURST_PARITY_EN.
- When defined:
  - Adds output parity_out (1 bit) = registered XOR-reduction of out, updated in the same edge as out.
  - Reset value 0. Valid on every cycle, including after load.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset mid-burst: load 31'h5, start N=10; assert rst on cycle 3 -> out=0, busy=0, done=0 immediately (before next edge); no done afterwards.
- Serial right, compatibility: load 31'h00000001, start N=1, dir=0, mode=00, serial_in=1 -> out=31'h40000000, serial_out=1, busy high 1 cycle, done pulse next cycle.
- Rotate left full turn: load 31'h12345678, start N=31, dir=1, mode=01 -> busy high exactly 31 cycles, out=31'h12345678 at done.
- LFSR sequence: load 31'h00000001, mode=10, dir=0, N=3 -> out after shifts = 31'h00000000, 31'h00000000, 31'h00000000. Then load 31'h48000000, N=1 -> in_bit = 1^1 = 0, out=31'h24000000.
- Zero-length and ignored start:
  - start N=0 -> done next cycle, out unchanged, busy never high.
  - start during busy with N=5 -> original burst length preserved.
- Load abort: start N=20, load 31'h7FFFFFFF on cycle 4 -> out=31'h7FFFFFFF, busy=0, no done pulse.
- With SHIFT_REG_BURST_PARITY_EN: load 31'h00000007 -> parity_out=1; one zero-fill right shift -> out=31'h00000003, parity_out=0.
